tone_synth: RTL and testbench

Parametrised successor to the three-note/two-volume-button buzzer path. It is a keyed square-wave synthesiser with NUM_KEYS notes, saturating volume levels, octave shift and an optional stereo harmony channel. It sits between the button one-pulse conditioners and the audio serialiser (Speaker), and exports volume and octave for the 7-segment display.

---
 rtl/tone_pkg.sv | 49 ++++
 rtl/tone_synth_gen.sv | 48 ++++
 rtl/tone_synth.sv | 170 +++++++++++++++++
 tb/tb_tone_synth.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_pkg
// Description : Note table, half-period and sizing helpers for tone_synth.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_pkg;

    typedef enum logic [2:0] {
        NOTE_C4 = 3'd0,
        NOTE_D4 = 3'd1,
        NOTE_E4 = 3'd2,
        NOTE_F4 = 3'd3,
        NOTE_G4 = 3'd4,
        NOTE_A4 = 3'd5,
        NOTE_B4 = 3'd6,
        NOTE_C5 = 3'd7
    } note_e;

    localparam int c_num_notes   = 8;
    localparam int c_harm_offset = 2;

    // Integer note frequencies in Hz, indexed by key number.
    function automatic int note_freq(input int k);
        case (k)
            0:       return 262;
            1:       return 294;
            2:       return 330;
            3:       return 349;
            4:       return 392;
            5:       return 440;
            6:       return 494;
            default: return 523;
        endcase
    endfunction

    function automatic int half_period(input int clk_hz, input int k);
        return clk_hz / (2 * note_freq(k));
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_synth_gen.sv
`default_nettype none
// ============================================================================
// Module      : tone_gen
// Description : Square-wave generator: half-period counter, phase flop and
//               signed amplitude stage with a synchronous restart.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_gen #(
    parameter int HALF_W  = 18,
    parameter int AUDIO_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_restart,
    input  logic [HALF_W-1:0]         i_half,
    input  logic [AUDIO_W-1:0]        i_amp,
    input  logic                      i_active,
    output logic signed [AUDIO_W-1:0] o_sample
);

    logic [HALF_W-1:0] r_cnt;
    logic              r_phase;
    logic              w_wrap;

    // A half period of 0 or 1 toggles every cycle rather than stalling.
    assign w_wrap = ({1'b0, r_cnt} + {{HALF_W{1'b0}}, 1'b1}) >= {1'b0, i_half};

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        o_sample = '0;
        if (i_active) begin
            o_sample = r_phase ? $signed(i_amp) : -$signed(i_amp);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tone_synth.sv
`default_nettype none
// ============================================================================
// Module      : tone_synth
// Description : Keyed square-wave synthesiser with saturating volume, octave
//               shift and an optional harmony voice on the right channel.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_synth
    import tone_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int NUM_KEYS = 8,
    parameter int VOL_W    = 4,
    parameter int VOL_INIT = 8,
    parameter int OCT_MAX  = 3,
    parameter int AUDIO_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_KEYS-1:0]    key_pulse,
    input  logic                   vol_up,
    input  logic                   vol_dn,
    input  logic                   oct_up,
    input  logic                   oct_dn,
    input  logic                   stereo_mode,
    output logic [AUDIO_W-1:0]     left_audio,
    output logic [AUDIO_W-1:0]     right_audio,
    output logic [VOL_W-1:0]       vol_level,
    output logic [((clog2(OCT_MAX+1) < 1) ? 1 : clog2(OCT_MAX+1))-1:0] octave,
    output logic [2:0]             note_idx,
    output logic                   playing
);

    localparam int c_oct_w     = (clog2(OCT_MAX+1) < 1) ? 1 : clog2(OCT_MAX+1);
    localparam int c_half_raw  = clog2(half_period(CLK_HZ, 0) + 1);
    localparam int c_half_w    = (c_half_raw < 1) ? 1 : c_half_raw;
    localparam int c_amp_shift = AUDIO_W - 1 - VOL_W;

    logic                       r_playing;
    logic [2:0]                 r_note;
    logic [VOL_W-1:0]           r_vol;
    logic [c_oct_w-1:0]         r_oct;
    logic signed [AUDIO_W-1:0]  r_left;
    logic signed [AUDIO_W-1:0]  r_right;

    logic                       w_key_hit;
    logic [2:0]                 w_key_idx;
    logic                       w_key_stop;
    logic                       w_key_start;
    logic                       w_vol_inc;
    logic                       w_vol_dec;
    logic                       w_oct_inc;
    logic                       w_oct_dec;
    logic                       w_restart;
    logic [3:0]                 w_harm_sum;
    logic                       w_harm_wrap;
    logic [2:0]                 w_harm_idx;
    logic [c_oct_w-1:0]         w_harm_oct;
    logic [c_half_w-1:0]        w_half_tab [c_num_notes];
    logic [c_half_w-1:0]        w_half_left;
    logic [c_half_w-1:0]        w_half_harm;
    logic [AUDIO_W-1:0]         w_amp;
    logic                       w_active;
    logic signed [AUDIO_W-1:0]  w_left_next;
    logic signed [AUDIO_W-1:0]  w_harm_next;

    // Lowest set key wins: scan from the top so the last hit is the lowest.
    always_comb begin
        w_key_hit = 1'b0;
        w_key_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_pulse[i]) begin
                w_key_hit = 1'b1;
                w_key_idx = 3'(i);
            end
        end
    end

    assign w_key_stop  = w_key_hit && r_playing && (w_key_idx == r_note);
    assign w_key_start = w_key_hit && !w_key_stop;

    assign w_vol_inc = vol_up && !vol_dn && (r_vol != {VOL_W{1'b1}});
    assign w_vol_dec = vol_dn && !vol_up && (r_vol != '0);
    assign w_oct_inc = oct_up && !oct_dn && (r_oct != c_oct_w'(OCT_MAX));
    assign w_oct_dec = oct_dn && !oct_up && (r_oct != '0);
    assign w_restart = w_key_start || w_oct_inc || w_oct_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_playing <= 1'b0;
            r_note    <= '0;
            r_vol     <= VOL_W'(VOL_INIT);
            r_oct     <= '0;
        end else begin
            if (w_key_stop) begin
                r_playing <= 1'b0;
            end else if (w_key_start) begin
                r_playing <= 1'b1;
                r_note    <= w_key_idx;
            end
            if (w_vol_inc) r_vol <= r_vol + 1'b1;
            if (w_vol_dec) r_vol <= r_vol - 1'b1;
            if (w_oct_inc) r_oct <= r_oct + 1'b1;
            if (w_oct_dec) r_oct <= r_oct - 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < c_num_notes; g++) begin : g_half_tab
            assign w_half_tab[g] = c_half_w'(half_period(CLK_HZ, g));
        end
    endgenerate

    // Harmony voice: key shifted up by the offset, folding into the next octave.
    assign w_harm_sum  = {1'b0, r_note} + 4'(c_harm_offset);
    assign w_harm_wrap = w_harm_sum >= 4'(NUM_KEYS);
    assign w_harm_idx  = w_harm_wrap ? 3'(w_harm_sum - 4'(NUM_KEYS)) : w_harm_sum[2:0];
    assign w_harm_oct  = (w_harm_wrap && (r_oct != c_oct_w'(OCT_MAX))) ? r_oct + 1'b1 : r_oct;

    assign w_half_left = w_half_tab[r_note] >> r_oct;
    assign w_half_harm = w_half_tab[w_harm_idx] >> w_harm_oct;

    assign w_amp    = {{(AUDIO_W-VOL_W){1'b0}}, r_vol} << c_amp_shift;
    assign w_active = r_playing && (r_vol != '0);

    tone_gen #(
        .HALF_W  (c_half_w),
        .AUDIO_W (AUDIO_W)
    ) u_left_gen (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .i_half    (w_half_left),
        .i_amp     (w_amp),
        .i_active  (w_active),
        .o_sample  (w_left_next)
    );

    tone_gen #(
        .HALF_W  (c_half_w),
        .AUDIO_W (AUDIO_W)
    ) u_harm_gen (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .i_half    (w_half_harm),
        .i_amp     (w_amp),
        .i_active  (w_active),
        .o_sample  (w_harm_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_left  <= '0;
            r_right <= '0;
        end else begin
            r_left  <= w_left_next;
            r_right <= stereo_mode ? w_harm_next : w_left_next;
        end
    end

    assign left_audio  = r_left;
    assign right_audio = r_right;
    assign vol_level   = r_vol;
    assign octave      = r_oct;
    assign note_idx    = r_note;
    assign playing     = r_playing;

endmodule
`default_nettype wire

// File: tb/tb_tone_synth.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_synth
// Description : Randomised self-checking bench for tone_synth against a
//               time-based reference model of the square-wave outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_synth;

    localparam int CLK_HZ   = 100000;
    localparam int NUM_KEYS = 8;
    localparam int VOL_W    = 4;
    localparam int VOL_INIT = 8;
    localparam int OCT_MAX  = 3;
    localparam int AUDIO_W  = 16;

    logic                clk;
    logic                rst;
    logic [NUM_KEYS-1:0] key_pulse;
    logic                vol_up, vol_dn, oct_up, oct_dn, stereo_mode;
    logic [AUDIO_W-1:0]  left_audio, right_audio;
    logic [VOL_W-1:0]    vol_level;
    logic [1:0]          octave;
    logic [2:0]          note_idx;
    logic                playing;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int cyc = 0;
    int m_play, m_note, m_vol, m_oct, m_t0;
    int exp_left, exp_right;
    int freq_tab [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

    tone_synth #(
        .CLK_HZ(CLK_HZ), .NUM_KEYS(NUM_KEYS), .VOL_W(VOL_W),
        .VOL_INIT(VOL_INIT), .OCT_MAX(OCT_MAX), .AUDIO_W(AUDIO_W)
    ) dut (
        .clk(clk), .rst(rst), .key_pulse(key_pulse),
        .vol_up(vol_up), .vol_dn(vol_dn), .oct_up(oct_up), .oct_dn(oct_dn),
        .stereo_mode(stereo_mode), .left_audio(left_audio),
        .right_audio(right_audio), .vol_level(vol_level), .octave(octave),
        .note_idx(note_idx), .playing(playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_half(input int k, input int o);
        int h;
        h = (CLK_HZ / (2 * freq_tab[k])) >> o;
        return (h < 1) ? 1 : h;
    endfunction

    // Level number since the restart decides the sign; each level lasts 'half' samples.
    function automatic int m_wave(input int half, input int n, input int vol);
        int amp;
        amp = vol * (1 << (AUDIO_W - 1 - VOL_W));
        return ((((n - 1) / half) % 2) == 0) ? amp : -amp;
    endfunction

    task automatic model_edge(input logic [7:0] kp, input logic vu, vd, ou, od, r);
        int h, ho, el, eh, k;
        if (r) begin
            m_play = 0; m_note = 0; m_vol = VOL_INIT; m_oct = 0; m_t0 = cyc;
            exp_left = 0; exp_right = 0;
            return;
        end
        el = 0; eh = 0;
        if (m_play != 0 && m_vol != 0) begin
            h  = (m_note + 2) % NUM_KEYS;
            ho = (m_note + 2 >= NUM_KEYS) ? ((m_oct + 1 > OCT_MAX) ? OCT_MAX : m_oct + 1) : m_oct;
            el = m_wave(m_half(m_note, m_oct), cyc - m_t0, m_vol);
            eh = m_wave(m_half(h, ho), cyc - m_t0, m_vol);
        end
        exp_left  = el;
        exp_right = stereo_mode ? eh : el;
        k = -1;
        for (int i = NUM_KEYS - 1; i >= 0; i--) if (kp[i]) k = i;
        if (k >= 0) begin
            if (m_play != 0 && k == m_note) m_play = 0;
            else begin m_note = k; m_play = 1; m_t0 = cyc; end
        end
        if (vu && !vd && m_vol < (1 << VOL_W) - 1) m_vol++;
        if (vd && !vu && m_vol > 0) m_vol--;
        if (ou && !od && m_oct < OCT_MAX) begin m_oct++; m_t0 = cyc; end
        if (od && !ou && m_oct > 0) begin m_oct--; m_t0 = cyc; end
    endtask

    task automatic tick(input logic [7:0] kp, input logic vu, vd, ou, od, r);
        key_pulse = kp[NUM_KEYS-1:0];
        vol_up = vu; vol_dn = vd; oct_up = ou; oct_dn = od; rst = r;
        @(posedge clk);
        cyc++;
        model_edge(kp, vu, vd, ou, od, r);
        #1;
        key_pulse = '0; vol_up = 0; vol_dn = 0; oct_up = 0; oct_dn = 0; rst = 0;
    endtask

    task automatic tick0();
        tick(8'h00, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        tick(8'h00, 0, 0, 0, 0, 1);
        tick(8'h00, 0, 0, 0, 0, 1);
        n_tests++; if (left_audio !== 16'h0000) begin n_fail++; $display("FAIL reset_left got %h want 0000", left_audio); end
        n_tests++; if (right_audio !== 16'h0000) begin n_fail++; $display("FAIL reset_right got %h want 0000", right_audio); end
        n_tests++; if (vol_level !== 4'd8) begin n_fail++; $display("FAIL reset_vol got %0d want 8", vol_level); end
        n_tests++; if (octave !== 2'd0) begin n_fail++; $display("FAIL reset_oct got %0d want 0", octave); end
        n_tests++; if (note_idx !== 3'd0) begin n_fail++; $display("FAIL reset_note got %0d want 0", note_idx); end
        n_tests++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing got %b want 0", playing); end
    endtask

    task automatic test_a4();
        int half;
        half = m_half(5, 0);
        tick(8'b0010_0000, 0, 0, 0, 0, 0);
        n_tests++; if (playing !== 1'b1 || note_idx !== 3'd5) begin n_fail++; $display("FAIL a4_state got play=%b note=%0d want 1/5", playing, note_idx); end
        tick0();
        n_tests++; if (left_audio !== 16'h4000) begin n_fail++; $display("FAIL a4_first got %h want 4000", left_audio); end
        for (int i = 2; i <= 3 * half; i++) begin
            tick0();
            n_tests++; if (left_audio !== 16'(exp_left)) begin n_fail++; $display("FAIL a4_wave cyc %0d got %h want %h", i, left_audio, 16'(exp_left)); end
            if (i == half + 1) begin
                n_tests++; if (left_audio !== 16'hC000) begin n_fail++; $display("FAIL a4_low got %h want c000", left_audio); end
            end
        end
    endtask

    task automatic test_octave();
        tick(8'h00, 0, 0, 1, 0, 0);
        n_tests++; if (octave !== 2'd1) begin n_fail++; $display("FAIL oct_up got %0d want 1", octave); end
        tick0();
        n_tests++; if (left_audio !== 16'h4000) begin n_fail++; $display("FAIL oct_restart got %h want 4000", left_audio); end
        for (int i = 0; i < 130; i++) begin
            tick0();
            n_tests++; if (left_audio !== 16'(exp_left)) begin n_fail++; $display("FAIL oct1_wave got %h want %h", left_audio, 16'(exp_left)); end
        end
        for (int i = 0; i < 3; i++) tick(8'h00, 0, 0, 1, 0, 0);
        n_tests++; if (octave !== 2'd3) begin n_fail++; $display("FAIL oct_sat got %0d want 3", octave); end
        for (int i = 0; i < 60; i++) begin
            tick0();
            n_tests++; if (left_audio !== 16'(exp_left)) begin n_fail++; $display("FAIL oct3_wave got %h want %h", left_audio, 16'(exp_left)); end
        end
    endtask

    task automatic test_volume();
        for (int i = 0; i < 10; i++) tick(8'h00, 1, 0, 0, 0, 0);
        n_tests++; if (vol_level !== 4'd15) begin n_fail++; $display("FAIL vol_sat_hi got %0d want 15", vol_level); end
        tick0();
        n_tests++; if (left_audio !== 16'd30720 && left_audio !== 16'(-30720)) begin n_fail++; $display("FAIL vol_amp got %h want +-30720", left_audio); end
        tick(8'h00, 1, 1, 0, 0, 0);
        n_tests++; if (vol_level !== 4'd15) begin n_fail++; $display("FAIL vol_both got %0d want 15", vol_level); end
        for (int i = 0; i < 15; i++) tick(8'h00, 0, 1, 0, 0, 0);
        n_tests++; if (vol_level !== 4'd0) begin n_fail++; $display("FAIL vol_sat_lo got %0d want 0", vol_level); end
        for (int i = 0; i < 20; i++) begin
            tick0();
            n_tests++; if (left_audio !== 16'h0000 || playing !== 1'b1) begin n_fail++; $display("FAIL vol_zero got %h play=%b want 0000 play=1", left_audio, playing); end
        end
    endtask

    task automatic test_key_priority();
        tick(8'h00, 1, 0, 0, 0, 0);
        tick(8'b0000_1001, 0, 0, 0, 0, 0);
        n_tests++; if (note_idx !== 3'd0 || playing !== 1'b1) begin n_fail++; $display("FAIL key_low got note=%0d play=%b want 0/1", note_idx, playing); end
        for (int i = 0; i < 40; i++) begin
            tick0();
            n_tests++; if (left_audio !== 16'(exp_left)) begin n_fail++; $display("FAIL c4_wave got %h want %h", left_audio, 16'(exp_left)); end
        end
        tick(8'b0000_0001, 0, 0, 0, 0, 0);
        n_tests++; if (playing !== 1'b0) begin n_fail++; $display("FAIL key_stop got %b want 0", playing); end
        tick0();
        n_tests++; if (left_audio !== 16'h0000 || right_audio !== 16'h0000) begin n_fail++; $display("FAIL stop_audio got %h/%h want 0000", left_audio, right_audio); end
    endtask

    task automatic test_stereo();
        for (int i = 0; i < 3; i++) tick(8'h00, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) tick(8'h00, 1, 0, 0, 0, 0);
        stereo_mode = 1'b1;
        tick(8'b0100_0000, 0, 0, 0, 0, 0);
        n_tests++; if (note_idx !== 3'd6 || octave !== 2'd0) begin n_fail++; $display("FAIL b4_state got note=%0d oct=%0d want 6/0", note_idx, octave); end
        for (int i = 0; i < 250; i++) begin
            tick0();
            n_tests++; if (right_audio !== 16'(exp_right)) begin n_fail++; $display("FAIL harm_wave got %h want %h", right_audio, 16'(exp_right)); end
            n_tests++; if (left_audio !== 16'(exp_left)) begin n_fail++; $display("FAIL b4_wave got %h want %h", left_audio, 16'(exp_left)); end
        end
        stereo_mode = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick0();
            n_tests++; if (right_audio !== left_audio || left_audio !== 16'(exp_left)) begin n_fail++; $display("FAIL mono got %h/%h want %h", left_audio, right_audio, 16'(exp_left)); end
        end
    endtask

    task automatic test_random();
        logic [7:0] kp;
        for (int i = 0; i < 3000; i++) begin
            kp = (($urandom % 25) == 0) ? 8'($urandom) : 8'h00;
            if (($urandom % 60) == 0) stereo_mode = ~stereo_mode;
            tick(kp, ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 30) == 0,
                 ($urandom % 30) == 0, ($urandom % 700) == 0);
            n_tests++; if (left_audio !== 16'(exp_left)) begin n_fail++; $display("FAIL rnd_left cyc %0d got %h want %h", cyc, left_audio, 16'(exp_left)); end
            n_tests++; if (right_audio !== 16'(exp_right)) begin n_fail++; $display("FAIL rnd_right cyc %0d got %h want %h", cyc, right_audio, 16'(exp_right)); end
            n_tests++; if (vol_level !== 4'(m_vol) || octave !== 2'(m_oct)) begin n_fail++; $display("FAIL rnd_voloct got %0d/%0d want %0d/%0d", vol_level, octave, m_vol, m_oct); end
            n_tests++; if (playing !== 1'(m_play) || note_idx !== 3'(m_note)) begin n_fail++; $display("FAIL rnd_note got %b/%0d want %0d/%0d", playing, note_idx, m_play, m_note); end
        end
    endtask

    task automatic test_reset_mid_note();
        tick(8'h00, 0, 0, 0, 0, 1);
        stereo_mode = 1'b1;
        tick(8'b0000_1000, 1, 0, 1, 0, 0);
        for (int i = 0; i < 30; i++) tick0();
        n_tests++; if (left_audio === 16'h0000) begin n_fail++; $display("FAIL pre_reset got %h want nonzero", left_audio); end
        tick(8'h00, 0, 0, 0, 0, 1);
        n_tests++; if (left_audio !== 16'h0000 || right_audio !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_audio got %h/%h want 0000", left_audio, right_audio); end
        n_tests++; if (vol_level !== 4'd8 || octave !== 2'd0 || playing !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state got vol=%0d oct=%0d play=%b want 8/0/0", vol_level, octave, playing); end
        tick0();
        n_tests++; if (left_audio !== 16'h0000 || right_audio !== 16'h0000) begin n_fail++; $display("FAIL post_rst_audio got %h/%h want 0000", left_audio, right_audio); end
    endtask

    initial begin
        rst = 1'b1; key_pulse = '0; vol_up = 0; vol_dn = 0; oct_up = 0; oct_dn = 0;
        stereo_mode = 1'b0;
        m_play = 0; m_note = 0; m_vol = VOL_INIT; m_oct = 0; m_t0 = 0;
        exp_left = 0; exp_right = 0;
        test_reset();
        test_a4();
        test_octave();
        test_volume();
        test_key_priority();
        test_stereo();
        test_random();
        test_reset_mid_note();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
